ro_buffer: RTL

Reorder buffer that sits at the receiving end of the issuer's dispatch interface. It allocates one entry per issued instruction and hands the next free entry id back to the issuer. It captures results broadcast on the reservation-station and load/store-buffer buses, answers the issuer's operand-forwarding lookups, and retires entries in program order. Retirement goes to the register file; stores are released to the load/store buffer, and branch mispredictions trigger a pipeline flush to the instruction fetcher.

---
 rtl/ro_buffer_pkg.sv | 17 +
 rtl/ro_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ro_buffer_pkg.sv
// rtl/ro_buffer_pkg.sv - shared constants and types for the reorder buffer
package ro_buffer_pkg;

  localparam int DEF_ROB_ID_WIDTH = 4;
  localparam int DEF_REG_WIDTH    = 32;
  localparam int DEF_REG_ID_WIDTH = 5;

  typedef enum logic [1:0] {
    SIG_NORMAL = 2'd0,
    SIG_STORE  = 2'd1,
    SIG_BRANCH = 2'd2
  } issue_sig_t;

  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_WAIT_STORE = 1'b1;

endpackage

// File: rtl/ro_buffer.sv
// rtl/ro_buffer.sv - reorder buffer: in-order allocate, out-of-order writeback, in-order commit
// Entry id 0 means "none"; ids 1..2^W-1 are usable and pointers wrap from the top id back to 1.
module ro_buffer
  import ro_buffer_pkg::*;
#(
  parameter int ROB_ID_WIDTH = DEF_ROB_ID_WIDTH,
  parameter int REG_WIDTH    = DEF_REG_WIDTH,
  parameter int REG_ID_WIDTH = DEF_REG_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic [ROB_ID_WIDTH-1:0] dest_to_issuer,
  output logic                    is_full,
  input  logic                    valid_from_issuer,
  input  logic [1:0]              signal_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [REG_WIDTH-1:0]    next_pc_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] qj_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] qk_from_issuer,
  output logic                    valid_of_vj_to_issuer,
  output logic                    valid_of_vk_to_issuer,
  output logic [REG_WIDTH-1:0]    vj_to_issuer,
  output logic [REG_WIDTH-1:0]    vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rss_bus,
  input  logic [REG_WIDTH-1:0]    value_from_rss_bus,
  input  logic [REG_WIDTH-1:0]    next_pc_from_rss_bus,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_lsb_bus,
  input  logic [REG_WIDTH-1:0]    value_from_lsb_bus,
  output logic [REG_ID_WIDTH-1:0] rd_to_reg_file,
  output logic [ROB_ID_WIDTH-1:0] dest_to_reg_file,
  output logic [REG_WIDTH-1:0]    value_to_reg_file,
  output logic [ROB_ID_WIDTH-1:0] store_dest_to_ls_buffer,
  input  logic                    store_done_from_ls_buffer,
  output logic                    flush,
  output logic [REG_WIDTH-1:0]    target_pc_to_inst_fetcher
);

  localparam int DEPTH       = 2 ** ROB_ID_WIDTH;
  localparam int NUM_ENTRIES = DEPTH - 1;
  localparam int CNT_W       = ROB_ID_WIDTH + 1;

  typedef logic [ROB_ID_WIDTH-1:0] id_t;

  logic                    busy_q    [DEPTH];
  logic                    ready_q   [DEPTH];
  issue_sig_t              sig_q     [DEPTH];
  logic [REG_ID_WIDTH-1:0] rd_q      [DEPTH];
  logic [REG_WIDTH-1:0]    value_q   [DEPTH];
  logic [REG_WIDTH-1:0]    pred_pc_q [DEPTH];
  logic [REG_WIDTH-1:0]    res_pc_q  [DEPTH];

  id_t              head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [0:0]       state_q;

  logic do_alloc, head_ok, commit_reg, start_store, free_head;

  function automatic id_t wrap_inc(input id_t id);
    return (id == {ROB_ID_WIDTH{1'b1}}) ? id_t'(1) : id + id_t'(1);
  endfunction

  // Look-ahead id and fullness cover the issuer's registered gap between sampling and valid.
  assign dest_to_issuer = valid_from_issuer ? wrap_inc(tail_q) : tail_q;
  assign is_full = (count_q + CNT_W'(valid_from_issuer)) >= CNT_W'(NUM_ENTRIES);

  assign valid_of_vj_to_issuer = (qj_from_issuer != '0) && busy_q[qj_from_issuer] && ready_q[qj_from_issuer];
  assign valid_of_vk_to_issuer = (qk_from_issuer != '0) && busy_q[qk_from_issuer] && ready_q[qk_from_issuer];
  assign vj_to_issuer = value_q[qj_from_issuer];
  assign vk_to_issuer = value_q[qk_from_issuer];

  always_comb begin
    do_alloc    = valid_from_issuer && !flush;
    head_ok     = busy_q[head_q] && ready_q[head_q] && !flush;
    commit_reg  = (state_q == ST_IDLE) && head_ok && (sig_q[head_q] != SIG_STORE);
    start_store = (state_q == ST_IDLE) && head_ok && (sig_q[head_q] == SIG_STORE);
    free_head   = commit_reg || ((state_q == ST_WAIT_STORE) && store_done_from_ls_buffer);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]    <= 1'b0;
        ready_q[i]   <= 1'b0;
        sig_q[i]     <= SIG_NORMAL;
        rd_q[i]      <= '0;
        value_q[i]   <= '0;
        pred_pc_q[i] <= '0;
        res_pc_q[i]  <= '0;
      end
      head_q                    <= id_t'(1);
      tail_q                    <= id_t'(1);
      count_q                   <= '0;
      state_q                   <= ST_IDLE;
      rd_to_reg_file            <= '0;
      dest_to_reg_file          <= '0;
      value_to_reg_file         <= '0;
      store_dest_to_ls_buffer   <= '0;
      flush                     <= 1'b0;
      target_pc_to_inst_fetcher <= '0;
    end else if (rdy) begin
      rd_to_reg_file    <= '0;
      dest_to_reg_file  <= '0;
      value_to_reg_file <= '0;
      flush             <= 1'b0;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          busy_q[i]  <= 1'b0;
          ready_q[i] <= 1'b0;
        end
        head_q                  <= id_t'(1);
        tail_q                  <= id_t'(1);
        count_q                 <= '0;
        state_q                 <= ST_IDLE;
        store_dest_to_ls_buffer <= '0;
      end else begin
        if (dest_from_rss_bus != '0 && busy_q[dest_from_rss_bus]) begin
          ready_q[dest_from_rss_bus]  <= 1'b1;
          value_q[dest_from_rss_bus]  <= value_from_rss_bus;
          res_pc_q[dest_from_rss_bus] <= next_pc_from_rss_bus;
        end
        if (dest_from_lsb_bus != '0 && busy_q[dest_from_lsb_bus]) begin
          ready_q[dest_from_lsb_bus] <= 1'b1;
          value_q[dest_from_lsb_bus] <= value_from_lsb_bus;
        end
        if (commit_reg) begin
          rd_to_reg_file    <= rd_q[head_q];
          dest_to_reg_file  <= head_q;
          value_to_reg_file <= value_q[head_q];
          if (sig_q[head_q] == SIG_BRANCH && res_pc_q[head_q] != pred_pc_q[head_q]) begin
            flush                     <= 1'b1;
            target_pc_to_inst_fetcher <= res_pc_q[head_q];
          end
        end
        if (start_store) begin
          store_dest_to_ls_buffer <= head_q;
          state_q                 <= ST_WAIT_STORE;
        end
        if (state_q == ST_WAIT_STORE && store_done_from_ls_buffer) begin
          store_dest_to_ls_buffer <= '0;
          state_q                 <= ST_IDLE;
        end
        if (free_head) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= wrap_inc(head_q);
        end
        if (do_alloc) begin
          busy_q[tail_q]    <= 1'b1;
          ready_q[tail_q]   <= 1'b0;
          sig_q[tail_q]     <= issue_sig_t'(signal_from_issuer);
          rd_q[tail_q]      <= rd_from_issuer;
          pred_pc_q[tail_q] <= next_pc_from_issuer;
          tail_q            <= wrap_inc(tail_q);
        end
        count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(free_head);
      end
    end
  end

endmodule
